matrix_in_decoder: RTL and testbench
====================================

# matrix_in_decoder

Receive-side decoder for the LED matrix driver serial link: it watches the `sdi`/`dclk`/`le`/`gclk` lines that the matrix output block drives into the driver-chip chain and turns them back into driver-level events. For every latch event it reports the command type, the latched 16-bit word, the pixel index and the GCLK count. It is used as an in-fabric loopback monitor and as the self-checking end of the matrix bench. It models one chip position in a daisy chain of `BOARDS` chips.

## Interface
- `BOARDS`, 2: number of chips in the daisy chain; sets the shift-register length to `BOARDS*16`.
- `TAP`, 0: chip position reported. 0 = the chip nearest `sdi`, which holds the last 16 bits shifted; `TAP` = k holds bits `[16k+15:16k]` of the chain register.
- `FRAME_WORDS`, 128: DATA latches per frame; the wrap point of `data_index`.
- `clk`  in  1: system clock. All link inputs are synchronous to it.
- `rst`  in  1: reset, asynchronous, active-low.
- `sdi`  in  1: serial data, MSB first.
- `dclk`  in  1: data clock; each rising edge shifts one bit.
- `le`  in  1: latch enable.
- `gclk`  in  1: grayscale clock.
- `cmd_valid`  out  1: one-cycle strobe; the command fields below are valid.
- `cmd`  out  3: command code. 0 DATA, 1 VSYNC, 2 CFG1, 3 CFG2, 4 ENABLE, 5 PREACT, 7 UNKNOWN.
- `word`  out  16: the selected 16-bit chain word at the latch event.
- `le_count`  out  5: number of `dclk` rising edges seen while `le` was high, saturating at 31.
- `data_index`  out  16: index of the DATA latch within the current frame.
- `gclk_count`  out  16: `gclk` rising edges since the last VSYNC, saturating at 16'hFFFF.

## Operation
- **Input stage:** `sdi`, `dclk`, `le` and `gclk` are registered once into `s_*`. The previous sample of each is kept in `p_*`.
- **dclk rise** (`s_dclk & ~p_dclk`):
  - shift `s_sdi` into the LSB of the `BOARDS*16` chain register;
  - if `s_le` = 1, increment the LE counter, saturating at 31.
- **le fall** (`p_le & ~s_le`):
  - capture the command fields and pulse `cmd_valid`;
  - clear the LE counter.
- **Command decode from the LE count:**
  - 1 → DATA; 3 → VSYNC; 4 → CFG1; 6 → CFG2; 12 → ENABLE; 14 → PREACT;
  - any other count, including 0 → UNKNOWN.
- **Field capture on DATA:**
  - `data_index` = current frame counter value;
  - the frame counter then increments, wrapping from `FRAME_WORDS-1` to 0.
- **Field capture on VSYNC:**
  - `gclk_count` = GCLK counter value;
  - the GCLK counter and the frame counter both clear to 0.
- **GCLK counter:** increments on `s_gclk & ~p_gclk`, saturating at 16'hFFFF. It is only cleared by VSYNC.
- **Other commands:** `data_index` and `gclk_count` hold their last captured values; `word` and `le_count` are always updated.
- **Simultaneous dclk rise and le fall:**
  - the shift occurs first and `word` reflects the new bit;
  - that edge is not counted, because `s_le` = 0.
- **GCLK rise in the same cycle as VSYNC decode:** the counter clears to 0 and the edge is dropped.
- **Reset** (asynchronous, any time):
  - all registers clear: chain register, counters, `s_*`, `p_*`;
  - outputs go to `cmd_valid` = 0, `cmd` = 0, `word` = 0, `le_count` = 0, `data_index` = 0, `gclk_count` = 0;
  - a transfer that was in progress is discarded; decoding resumes with the next `le` fall after reset is released.

## Timing
- `cmd_valid` goes high on the second `clk` rising edge after `le` = 0 is first presented at the port, and stays high for exactly 1 cycle.
- All command fields are registered and change only in the cycle `cmd_valid` goes high.
- Input handling:
  - `dclk` high and low phases must each be at least 1 `clk` cycle; the matrix output block guarantees this.
  - Input pulses of 1 cycle are captured.
  - No metastability synchronizers are used; all inputs are same-domain.
- Throughput: back-to-back latch events at least 2 cycles apart each produce their own strobe.

## Test plan
- **PREACT:** 16 `dclk` pulses at 2 clk/bit, `le` high on bits 1–14 → one strobe with `cmd` = 5, `le_count` = 14, 2 cycles after `le` falls.
- **CFG1 with BOARDS=2, TAP=0:** shift 32 bits of 16'h0370 repeated, `le` high on the last 4 bits → `cmd` = 2, `word` = 16'h0370.
- **Frame of DATA latches:** 128 DATA words with values 16'h0000..16'h007F, `le` high on the last bit of every second word (one latch per 2 words) → strobes with `cmd` = 0 and `data_index` 0..63; then send 64 more latches → `data_index` continues 64..127, then wraps to 0.
- **VSYNC:** 300 `gclk` pulses, then `le` high for 3 bits → `cmd` = 1, `gclk_count` = 300; the next DATA latch gives `data_index` = 0.
- **UNKNOWN:** `le` high for 5 bits → `cmd` = 7, `le_count` = 5. `le` high for 40 bits → `le_count` = 31 (saturated), `cmd` = 7.
- **Reset mid-transfer:** assert `rst` low after 10 shifted bits with `le` high → all outputs 0 immediately. After release, a clean DATA latch decodes with `le_count` = 1.

Source files
------------

// File: rtl/matrix_in_decoder.sv
// matrix_in_decoder: decodes the LED driver serial link (sdi/dclk/le/gclk) back into latch events.
module matrix_in_decoder #(
  parameter int BOARDS = 2,
  parameter int TAP = 0,
  parameter int FRAME_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi,
  input  logic        dclk,
  input  logic        le,
  input  logic        gclk,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [15:0] word,
  output logic [4:0]  le_count,
  output logic [15:0] data_index,
  output logic [15:0] gclk_count
);
  localparam int W = BOARDS * 16;
  logic s_sdi, s_dclk, s_le, s_gclk, p_dclk, p_le, p_gclk;
  logic dclk_rise, le_fall, gclk_rise, is_data, is_vsync;
  logic [W-1:0] chain, chain_nx;
  logic [4:0] le_cnt;
  logic [15:0] frame, gcnt;
  logic [2:0] dec;
  // word samples chain_nx so a dclk rise coinciding with the le fall is already shifted in
  always_comb begin
    dclk_rise = s_dclk & ~p_dclk;
    le_fall = p_le & ~s_le;
    gclk_rise = s_gclk & ~p_gclk;
    chain_nx = dclk_rise ? {chain[W-2:0], s_sdi} : chain;
    dec = le_cnt == 5'd1  ? 3'd0 :
          le_cnt == 5'd3  ? 3'd1 :
          le_cnt == 5'd4  ? 3'd2 :
          le_cnt == 5'd6  ? 3'd3 :
          le_cnt == 5'd12 ? 3'd4 :
          le_cnt == 5'd14 ? 3'd5 : 3'd7;
    is_data = le_fall & (dec == 3'd0);
    is_vsync = le_fall & (dec == 3'd1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s_sdi, s_dclk, s_le, s_gclk} <= '0;
      {p_dclk, p_le, p_gclk} <= '0;
      chain <= '0;
      le_cnt <= '0;
      frame <= '0;
      gcnt <= '0;
      cmd_valid <= 1'b0;
      cmd <= '0;
      word <= '0;
      le_count <= '0;
      data_index <= '0;
      gclk_count <= '0;
    end else begin
      {s_sdi, s_dclk, s_le, s_gclk} <= {sdi, dclk, le, gclk};
      {p_dclk, p_le, p_gclk} <= {s_dclk, s_le, s_gclk};
      chain <= chain_nx;
      cmd_valid <= le_fall;
      if (le_fall) le_cnt <= '0;
      else if (dclk_rise & s_le & (le_cnt != 5'd31)) le_cnt <= le_cnt + 5'd1;
      if (le_fall) begin
        cmd <= dec;
        word <= chain_nx[16*TAP +: 16];
        le_count <= le_cnt;
      end
      if (is_data) begin
        data_index <= frame;
        frame <= (frame == 16'(FRAME_WORDS - 1)) ? '0 : frame + 16'd1;
      end
      if (is_vsync) begin
        gclk_count <= gcnt;
        gcnt <= '0;
        frame <= '0;
      end else if (gclk_rise & (gcnt != 16'hFFFF)) gcnt <= gcnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_matrix_in_decoder.sv
// tb_matrix_in_decoder: randomized link stimulus, transaction model and scoreboard for matrix_in_decoder.
module tb_matrix_in_decoder;
  localparam int BOARDS = 2, TAP = 0, FW = 128, W = BOARDS * 16;
  logic clk = 0, rst = 1, sdi = 0, dclk = 0, le = 0, gclk = 0;
  logic cmd_valid;
  logic [2:0] cmd;
  logic [15:0] word, data_index, gclk_count;
  logic [4:0] le_count;
  int cyc = 0, n_vec = 0, n_bad = 0;
  typedef struct {
    logic [2:0] cmd;
    logic [15:0] word;
    logic [4:0] lc;
    logic [15:0] di, gc;
    int cyc;
  } exp_t;
  exp_t q[$];
  logic [W-1:0] m_chain;
  int m_cnt, m_frame, m_gclk, m_di, m_gc;
  logic m_pd, m_pl, m_pg;

  matrix_in_decoder #(.BOARDS(BOARDS), .TAP(TAP), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .sdi(sdi), .dclk(dclk), .le(le), .gclk(gclk),
    .cmd_valid(cmd_valid), .cmd(cmd), .word(word), .le_count(le_count),
    .data_index(data_index), .gclk_count(gclk_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] code(input int n);
    case (n)
      1: return 3'd0;
      3: return 3'd1;
      4: return 3'd2;
      6: return 3'd3;
      12: return 3'd4;
      14: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] lo(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic model_reset();
    m_chain = '0;
    {m_cnt, m_frame, m_gclk, m_di, m_gc} = '0;
    {m_pd, m_pl, m_pg} = '0;
  endtask

  task automatic model_step(input logic d, input logic s, input logic l, input logic g);
    exp_t e;
    bit vs;
    vs = 0;
    if (d && !m_pd) begin
      m_chain = {m_chain[W-2:0], s};
      if (l) m_cnt++;
    end
    if (m_pl && !l) begin
      e.cmd = code(m_cnt);
      e.word = m_chain[16*TAP +: 16];
      e.lc = 5'((m_cnt > 31) ? 31 : m_cnt);
      if (e.cmd == 3'd0) begin
        m_di = m_frame;
        m_frame = (m_frame + 1) % FW;
      end
      if (e.cmd == 3'd1) begin
        m_gc = (m_gclk > 65535) ? 65535 : m_gclk;
        m_gclk = 0;
        m_frame = 0;
        vs = 1;
      end
      e.di = 16'(m_di);
      e.gc = 16'(m_gc);
      e.cyc = cyc;
      q.push_back(e);
      m_cnt = 0;
    end
    if (g && !m_pg && !vs) m_gclk++;
    m_pd = d;
    m_pl = l;
    m_pg = g;
  endtask

  task automatic drive(input logic d, input logic s, input logic l, input logic g);
    @(posedge clk);
    #1;
    dclk = d;
    sdi = s;
    le = l;
    gclk = g;
    model_step(d, s, l, g);
  endtask

  task automatic send_bits(input logic [63:0] data, input int nb, input logic [63:0] mask, input bit rg);
    for (int i = nb - 1; i >= 0; i--) begin
      drive(1'b0, data[i], mask[i], rg ? 1'($urandom) : 1'b0);
      drive(1'b1, data[i], mask[i], rg ? 1'($urandom) : 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_cmd"}, 32'(cmd), 0);
    chk({tag, "_word"}, 32'(word), 0);
    chk({tag, "_le_count"}, 32'(le_count), 0);
    chk({tag, "_data_index"}, 32'(data_index), 0);
    chk({tag, "_gclk_count"}, 32'(gclk_count), 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d strobes missing, expected 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst && cmd_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got cmd=%0d expected no strobe", cmd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 32'(cyc), 32'(e.cyc + 2));
        chk("cmd", 32'(cmd), 32'(e.cmd));
        chk("word", 32'(word), 32'(e.word));
        chk("le_count", 32'(le_count), 32'(e.lc));
        chk("data_index", 32'(data_index), 32'(e.di));
        chk("gclk_count", 32'(gclk_count), 32'(e.gc));
      end
    end
  end

  initial begin
    logic [15:0] d;
    int opts[7];
    int n, nb;
    opts = '{1, 3, 4, 6, 12, 14, 0};
    model_reset();
    #3 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1;
    send_bits(64'($urandom), 16, 64'h7FFE, 0);
    idle(3);
    send_bits({32'h0, 16'h0370, 16'h0370}, 32, lo(4), 0);
    idle(3);
    for (int w = 0; w < 128; w++) send_bits(64'(w), 16, (w % 2 == 1) ? lo(1) : 64'h0, 0);
    idle(2);
    for (int k = 0; k < 65; k++) send_bits({$urandom, $urandom}, 32, lo(1), 1);
    idle(3);
    send_bits(64'h0, 3, lo(3), 0);
    idle(2);
    repeat (300) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    send_bits(64'($urandom), 3, lo(3), 0);
    idle(2);
    send_bits(64'($urandom), 16, lo(1), 0);
    idle(3);
    d = 16'($urandom);
    send_bits(64'(d[15:1]), 15, lo(1), 0);
    drive(1'b0, d[0], 1'b1, 1'b0);
    drive(1'b1, d[0], 1'b0, 1'b0);
    idle(3);
    send_bits(64'h0, 3, lo(3), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    send_bits(64'h0, 3, lo(3), 0);
    idle(3);
    send_bits(64'($urandom), 8, lo(5), 0);
    idle(1);
    send_bits({$urandom, $urandom}, 48, lo(40), 0);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    repeat (30) begin
      n = opts[$urandom_range(0, 6)];
      if (n == 0) n = $urandom_range(0, 35);
      if (n == 0) drive(1'b0, 1'b0, 1'b1, 1'($urandom));
      else begin
        nb = n + $urandom_range(0, 20);
        send_bits({$urandom, $urandom}, nb, lo(n), 1);
      end
      idle($urandom_range(0, 2));
    end
    idle(3);
    drain();
    send_bits(64'($urandom), 10, lo(10), 0);
    #2 rst = 0;
    #1;
    chk_zero("async_reset");
    model_reset();
    {sdi, dclk, le, gclk} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    send_bits(64'($urandom), 16, lo(1), 0);
    idle(3);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
